dma_priority_arbiter: RTL and testbench
=======================================

Name: dma_priority_arbiter

Overview:
- Channel arbiter and bus-hold sequencer for the 4-channel 8237-style DMA controller.
- Merges hardware DREQ lines, mask bits and software requests, then runs the HRQ/HLDA handshake with the CPU.
- Selects one channel under fixed or rotating priority and holds its DACK until timing control reports the end of service.
- Owns `priorityOrder`, which the timing-control block and the status register consume.

Parameters:
- `NUM_CH`, 4, number of DMA channels. Only 4 is supported.
- `DEFAULT_ORDER`, 8'b11_10_01_00, priority order after reset. Field [1:0] is the highest-priority channel.

Ports:
- `CLK`  in  1  system clock; all state updates on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `DREQ`  in  4  hardware DMA requests, active-high, one per channel.
- `HLDA`  in  1  hold acknowledge from the CPU.
- `maskBits`  in  4  per-channel mask; 1 blocks that channel's DREQ.
- `softwareReq`  in  4  request-register bits; not affected by the mask.
- `controllerDisable`  in  1  command register bit 2; 1 suppresses new arbitration.
- `priorityType`  in  1  0 = fixed priority, 1 = rotating priority.
- `serviceDone`  in  1  one-cycle pulse from timing control at the end of the serviced transfer.
- `HRQ`  out  1  hold request to the CPU.
- `DACK`  out  4  one-hot grant, active-high.
- `activeChannel`  out  2  index of the granted channel.
- `channelValid`  out  1  1 while a grant is held.
- `priorityOrder`  out  8  current order; four 2-bit channel fields.
- `requestPending`  out  4  effective requests; feeds status register bits 7:4.
- `softReqClear`  out  4  one-cycle pulse clearing the serviced channel's request bit.

Behaviour:
- Effective request: `effReq = (DREQ & ~maskBits) | softwareReq`.
  - Computed combinationally.
  - `requestPending` is `effReq` registered by one cycle.
- State machine: IDLE, REQ, GRANT, DONE, one-hot encoded.
- All outputs are registered.
- Reset values:
  - state = IDLE
  - `HRQ` = 0, `DACK` = 4'b0000, `activeChannel` = 0, `channelValid` = 0
  - `priorityOrder` = `DEFAULT_ORDER`
  - `requestPending` = 0, `softReqClear` = 0
- RESET has priority over every other event, including a grant that is mid-service.
- IDLE:
  - If `|effReq && !controllerDisable`, go to REQ. `HRQ` rises on the same clock edge, so it is seen 1 cycle after the request is sampled.
- REQ:
  - `HRQ` is held at 1.
  - If `effReq == 0` before HLDA arrives, go to IDLE and drop `HRQ`.
  - On a cycle where `HLDA == 1` and `effReq != 0`:
    - Pick the first channel in `priorityOrder` scan order ([1:0] first, [7:6] last) whose `effReq` bit is set.
    - Latch that channel and go to GRANT.
    - `DACK` one-hot, `activeChannel` and `channelValid` assert on the same edge.
  - There is no fixed bound on how long REQ waits for HLDA.
- GRANT:
  - `DACK` is stable; arbitration is frozen.
  - New requests, and the granted channel's DREQ dropping, have no effect.
  - On `serviceDone`, go to DONE.
  - If `HLDA` falls before `serviceDone` (abort):
    - Go directly to IDLE.
    - `DACK`, `HRQ` and `channelValid` clear.
    - No rotation and no `softReqClear`.
- DONE (exactly 1 cycle):
  - `DACK` = 0, `channelValid` = 0, `HRQ` = 0.
  - `softReqClear[c]` pulses for 1 cycle if `softwareReq[c]` was set.
  - If `priorityType == 1`, set `priorityOrder` to {c, c+3, c+2, c+1} in fields [7:6]..[1:0], arithmetic mod 4.
    - The serviced channel becomes lowest priority; c+1 becomes highest.
  - Then go to IDLE.
  - HRQ therefore drops for at least 1 cycle between services; back-to-back requests re-arbitrate from IDLE.
- Fixed mode:
  - While `priorityType == 0`, `priorityOrder` reloads `DEFAULT_ORDER` on every clock in IDLE.
  - Switching from rotating to fixed takes effect at the next IDLE cycle.
- `controllerDisable`:
  - Asserted in REQ: drop `HRQ` and return to IDLE.
  - Asserted in GRANT: ignored until DONE.
- `serviceDone` in any state other than GRANT is ignored.
- Invariant: `DACK` is always one-hot or zero, and `DACK != 0` implies `HRQ == 1 && channelValid == 1`.

Decomposition:
- Package `dma_pkg`:
  - `arbState_t` enum (IDLE/REQ/GRANT/DONE)
  - `channel_t` (logic [1:0])
  - `DEFAULT_PRIORITY_ORDER` constant
  - `NUM_CHANNELS` constant
  - `rotateOrder(channel_t)` function
- One combinational sub-module, `dma_priority_resolver`:
  - Inputs: `effReq`, `priorityOrder`.
  - Outputs: `winner` (`channel_t`) and `anyReq`.
  - Reused by the checker/reference model.

Test Plan:
- Fixed priority: RESET 1 cycle, then `DREQ` = 4'b0110, `HLDA` = 1 → `HRQ` at cycle +1, `DACK` = 4'b0010 at cycle +2, `activeChannel` = 1, `priorityOrder` stays 8'b11_10_01_00.
- Rotating priority: `priorityType` = 1, `DREQ` = 4'b1111; service ch0 with `serviceDone` → `priorityOrder` = 8'b00_11_10_01; next grant is `DACK` = 4'b0010; after that `priorityOrder` = 8'b01_00_11_10.
- Mask and software request: `maskBits` = 4'b0001, `DREQ` = 4'b0001, `softwareReq` = 4'b1000 → `DACK` = 4'b1000; in DONE `softReqClear` = 4'b1000 for 1 cycle; DREQ0 is never granted.
- HLDA delay and withdrawal: `DREQ` = 4'b0100 with HLDA low for 5 cycles → `HRQ` held 1, `DACK` = 0; DREQ drops before HLDA → `HRQ` = 0 the next cycle, state IDLE.
- Abort: in GRANT on ch2, drop `HLDA` → the next cycle `DACK` = 0, `HRQ` = 0, `priorityOrder` unchanged (rotating mode).
- Reset mid-grant: assert RESET while `DACK` = 4'b0001 → after the edge `DACK` = 0, `HRQ` = 0, `priorityOrder` = 8'b11_10_01_00, `requestPending` = 0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the 4-channel DMA controller.
//   arbState_t       : one-hot arbiter state encoding
//   channel_t        : 2-bit channel index
//   rotateOrder()    : priority order after servicing a channel in rotating mode
package dma_pkg;

    localparam int unsigned NUM_CHANNELS = 4;
    localparam int unsigned CH_W         = 2;
    localparam int unsigned ORDER_W      = NUM_CHANNELS * CH_W;

    // Field [1:0] holds the highest-priority channel, [7:6] the lowest.
    localparam logic [ORDER_W-1:0] DEFAULT_PRIORITY_ORDER = 8'b11_10_01_00;

    typedef logic [CH_W-1:0] channel_t;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        REQ   = 4'b0010,
        GRANT = 4'b0100,
        DONE  = 4'b1000
    } arbState_t;

    // Serviced channel drops to lowest priority; the next one up becomes highest.
    function automatic logic [ORDER_W-1:0] rotateOrder(input channel_t c);
        rotateOrder = {c, channel_t'(c + 2'd3), channel_t'(c + 2'd2), channel_t'(c + 2'd1)};
    endfunction

endpackage

// File: rtl/dma_priority_resolver.sv
// Combinational priority scan over the current order.
//   effReq        in  : effective per-channel requests
//   priorityOrder in  : four 2-bit channel fields, [1:0] scanned first
//   winner        out : first requesting channel in scan order (0 when none)
//   anyReq        out : at least one request present
module dma_priority_resolver
    import dma_pkg::*;
(
    input  logic [NUM_CHANNELS-1:0] effReq,
    input  logic [ORDER_W-1:0]      priorityOrder,
    output channel_t                winner,
    output logic                    anyReq
);

    channel_t w_winner;

    // Scan lowest priority first so the highest-priority hit is written last.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (effReq[priorityOrder[CH_W*i +: CH_W]]) begin
                w_winner = priorityOrder[CH_W*i +: CH_W];
            end
        end
    end

    assign winner = w_winner;
    assign anyReq = |effReq;

endmodule

// File: rtl/dma_priority_arbiter.sv
// Channel arbiter and bus-hold sequencer for the 8237-style DMA controller.
//   CLK, RESET            : clock, synchronous active-high reset
//   DREQ, maskBits        : hardware requests and their per-channel mask
//   softwareReq           : request-register bits (unmasked)
//   HLDA, HRQ             : CPU hold handshake
//   controllerDisable     : blocks new arbitration
//   priorityType          : 0 fixed, 1 rotating
//   serviceDone           : end-of-service pulse from timing control
//   DACK, activeChannel,
//   channelValid          : held grant
//   priorityOrder         : current scan order
//   requestPending        : registered effective requests
//   softReqClear          : pulse clearing a serviced software request
module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned        NUM_CH        = NUM_CHANNELS,
    parameter logic [ORDER_W-1:0] DEFAULT_ORDER = DEFAULT_PRIORITY_ORDER
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic [NUM_CH-1:0] maskBits,
    input  logic [NUM_CH-1:0] softwareReq,
    input  logic              controllerDisable,
    input  logic              priorityType,
    input  logic              serviceDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output channel_t          activeChannel,
    output logic              channelValid,
    output logic [ORDER_W-1:0] priorityOrder,
    output logic [NUM_CH-1:0] requestPending,
    output logic [NUM_CH-1:0] softReqClear
);

    arbState_t          r_state;
    logic               r_hrq;
    logic [NUM_CH-1:0]  r_dack;
    channel_t           r_ch;
    logic               r_valid;
    logic [ORDER_W-1:0] r_order;
    logic [NUM_CH-1:0]  r_pend;
    logic [NUM_CH-1:0]  r_src;

    arbState_t          w_state_nxt;
    logic               w_hrq_nxt;
    logic [NUM_CH-1:0]  w_dack_nxt;
    channel_t           w_ch_nxt;
    logic               w_valid_nxt;
    logic [ORDER_W-1:0] w_order_nxt;
    logic [NUM_CH-1:0]  w_src_nxt;

    logic [NUM_CH-1:0]  w_eff_req;
    channel_t           w_winner;
    logic               w_any_req;

    assign w_eff_req = (DREQ & ~maskBits) | softwareReq;

    dma_priority_resolver u_resolver (
        .effReq        (w_eff_req),
        .priorityOrder (r_order),
        .winner        (w_winner),
        .anyReq        (w_any_req)
    );

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_hrq   <= 1'b0;
            r_dack  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_order <= DEFAULT_ORDER;
            r_pend  <= '0;
            r_src   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hrq   <= w_hrq_nxt;
            r_dack  <= w_dack_nxt;
            r_ch    <= w_ch_nxt;
            r_valid <= w_valid_nxt;
            r_order <= w_order_nxt;
            r_pend  <= w_eff_req;
            r_src   <= w_src_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_hrq_nxt   = r_hrq;
        w_dack_nxt  = r_dack;
        w_ch_nxt    = r_ch;
        w_valid_nxt = r_valid;
        w_order_nxt = r_order;
        w_src_nxt   = '0;

        unique case (r_state)
            IDLE: begin
                if (!priorityType) begin
                    w_order_nxt = DEFAULT_ORDER;
                end
                if (w_any_req && !controllerDisable) begin
                    w_state_nxt = REQ;
                    w_hrq_nxt   = 1'b1;
                end
            end
            REQ: begin
                // Disable and withdrawal both win over a same-cycle HLDA.
                if (controllerDisable || !w_any_req) begin
                    w_state_nxt = IDLE;
                    w_hrq_nxt   = 1'b0;
                end else if (HLDA) begin
                    w_state_nxt = GRANT;
                    w_dack_nxt  = NUM_CH'(1) << w_winner;
                    w_ch_nxt    = w_winner;
                    w_valid_nxt = 1'b1;
                end
            end
            GRANT: begin
                // Losing the bus aborts the service without rotation or clear.
                if (!HLDA) begin
                    w_state_nxt = IDLE;
                    w_hrq_nxt   = 1'b0;
                    w_dack_nxt  = '0;
                    w_valid_nxt = 1'b0;
                end else if (serviceDone) begin
                    w_state_nxt = DONE;
                    w_hrq_nxt   = 1'b0;
                    w_dack_nxt  = '0;
                    w_valid_nxt = 1'b0;
                    w_src_nxt   = softwareReq & r_dack;
                    if (priorityType) begin
                        w_order_nxt = rotateOrder(r_ch);
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_hrq_nxt   = 1'b0;
                w_dack_nxt  = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign HRQ            = r_hrq;
    assign DACK           = r_dack;
    assign activeChannel  = r_ch;
    assign channelValid   = r_valid;
    assign priorityOrder  = r_order;
    assign requestPending = r_pend;
    assign softReqClear   = r_src;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: expectations are queued with each
// stimulus step and compared after the following clock edge.
module tb_dma_priority_arbiter;

    logic       CLK;
    logic       RESET;
    logic [3:0] DREQ;
    logic       HLDA;
    logic [3:0] maskBits;
    logic [3:0] softwareReq;
    logic       controllerDisable;
    logic       priorityType;
    logic       serviceDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] activeChannel;
    logic       channelValid;
    logic [7:0] priorityOrder;
    logic [3:0] requestPending;
    logic [3:0] softReqClear;

    localparam int S_HRQ   = 0;
    localparam int S_DACK  = 1;
    localparam int S_CH    = 2;
    localparam int S_VALID = 3;
    localparam int S_ORDER = 4;
    localparam int S_PEND  = 5;
    localparam int S_SRC   = 6;

    typedef struct {
        string      tag;
        int         sig;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_pass;
    int   n_total;

    dma_priority_arbiter dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .DREQ              (DREQ),
        .HLDA              (HLDA),
        .maskBits          (maskBits),
        .softwareReq       (softwareReq),
        .controllerDisable (controllerDisable),
        .priorityType      (priorityType),
        .serviceDone       (serviceDone),
        .HRQ               (HRQ),
        .DACK              (DACK),
        .activeChannel     (activeChannel),
        .channelValid      (channelValid),
        .priorityOrder     (priorityOrder),
        .requestPending    (requestPending),
        .softReqClear      (softReqClear)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] observe(input int sig);
        case (sig)
            S_HRQ:   observe = {7'd0, HRQ};
            S_DACK:  observe = {4'd0, DACK};
            S_CH:    observe = {6'd0, activeChannel};
            S_VALID: observe = {7'd0, channelValid};
            S_ORDER: observe = priorityOrder;
            S_PEND:  observe = {4'd0, requestPending};
            S_SRC:   observe = {4'd0, softReqClear};
            default: observe = 8'hxx;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sig, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, want);
    endtask

    // Advance one clock, then drain the scoreboard against the registered outputs.
    task automatic step();
        exp_t       e;
        logic [7:0] onehot_ok;
        @(posedge CLK);
        #1;
        onehot_ok = {7'd0, ((DACK & (DACK - 4'd1)) == 4'd0) &&
                           ((DACK == 4'd0) || (HRQ && channelValid))};
        check("dack_invariant", onehot_ok, 8'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sig), e.val);
        end
    endtask

    initial begin
        n_pass            = 0;
        n_total           = 0;
        RESET             = 1'b1;
        DREQ              = 4'b0000;
        HLDA              = 1'b0;
        maskBits          = 4'b0000;
        softwareReq       = 4'b0000;
        controllerDisable = 1'b0;
        priorityType      = 1'b0;
        serviceDone       = 1'b0;

        // Reset state
        push_exp("rst_hrq",   S_HRQ,   8'h0);
        push_exp("rst_dack",  S_DACK,  8'h0);
        push_exp("rst_ch",    S_CH,    8'h0);
        push_exp("rst_valid", S_VALID, 8'h0);
        push_exp("rst_order", S_ORDER, 8'hE4);
        push_exp("rst_pend",  S_PEND,  8'h0);
        push_exp("rst_src",   S_SRC,   8'h0);
        step();
        RESET = 1'b0;

        // Fixed priority: channel 1 beats channel 2
        DREQ = 4'b0110;
        HLDA = 1'b1;
        push_exp("fix_hrq1",  S_HRQ,  8'h1);
        push_exp("fix_dack1", S_DACK, 8'h0);
        push_exp("fix_pend",  S_PEND, 8'h6);
        step();
        push_exp("fix_dack",  S_DACK,  8'h2);
        push_exp("fix_ch",    S_CH,    8'h1);
        push_exp("fix_valid", S_VALID, 8'h1);
        push_exp("fix_order", S_ORDER, 8'hE4);
        step();
        DREQ = 4'b0001;
        push_exp("fix_frozen", S_DACK, 8'h2);
        step();
        serviceDone = 1'b1;
        DREQ        = 4'b0000;
        push_exp("fix_done_dack",  S_DACK,  8'h0);
        push_exp("fix_done_hrq",   S_HRQ,   8'h0);
        push_exp("fix_done_valid", S_VALID, 8'h0);
        push_exp("fix_done_order", S_ORDER, 8'hE4);
        push_exp("fix_done_src",   S_SRC,   8'h0);
        step();
        serviceDone = 1'b0;
        push_exp("fix_idle_hrq", S_HRQ, 8'h0);
        step();

        // Rotating priority
        priorityType = 1'b1;
        DREQ         = 4'b1111;
        push_exp("rot_hrq", S_HRQ, 8'h1);
        step();
        push_exp("rot_dack0", S_DACK, 8'h1);
        step();
        serviceDone = 1'b1;
        push_exp("rot_order1", S_ORDER, 8'h39);
        push_exp("rot_done_dack", S_DACK, 8'h0);
        step();
        serviceDone = 1'b0;
        push_exp("rot_idle_hrq",  S_HRQ,   8'h0);
        push_exp("rot_idle_keep", S_ORDER, 8'h39);
        step();
        push_exp("rot_hrq2", S_HRQ, 8'h1);
        step();
        push_exp("rot_dack1", S_DACK, 8'h2);
        push_exp("rot_ch1",   S_CH,   8'h1);
        step();
        serviceDone = 1'b1;
        push_exp("rot_order2", S_ORDER, 8'h4E);
        step();
        serviceDone = 1'b0;
        DREQ        = 4'b0000;
        HLDA        = 1'b0;
        step();
        priorityType = 1'b0;
        push_exp("fixed_reload", S_ORDER, 8'hE4);
        step();

        // Mask and software request
        maskBits    = 4'b0001;
        DREQ        = 4'b0001;
        softwareReq = 4'b1000;
        HLDA        = 1'b1;
        push_exp("sw_hrq",  S_HRQ,  8'h1);
        push_exp("sw_pend", S_PEND, 8'h8);
        step();
        push_exp("sw_dack", S_DACK, 8'h8);
        push_exp("sw_ch",   S_CH,   8'h3);
        step();
        serviceDone = 1'b1;
        push_exp("sw_src", S_SRC, 8'h8);
        step();
        serviceDone = 1'b0;
        softwareReq = 4'b0000;
        push_exp("sw_src_clr", S_SRC, 8'h0);
        step();
        push_exp("mask_hrq",  S_HRQ,  8'h0);
        push_exp("mask_dack", S_DACK, 8'h0);
        step();
        maskBits = 4'b0000;
        DREQ     = 4'b0000;
        step();

        // HLDA delay and withdrawal
        HLDA = 1'b0;
        DREQ = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            push_exp("wait_hrq",  S_HRQ,  8'h1);
            push_exp("wait_dack", S_DACK, 8'h0);
            step();
        end
        DREQ = 4'b0000;
        push_exp("wd_hrq",   S_HRQ,   8'h0);
        push_exp("wd_valid", S_VALID, 8'h0);
        step();

        // Abort in rotating mode
        priorityType = 1'b1;
        DREQ         = 4'b0100;
        HLDA         = 1'b1;
        step();
        push_exp("ab_dack", S_DACK, 8'h4);
        step();
        HLDA = 1'b0;
        DREQ = 4'b0000;
        push_exp("ab_dack0", S_DACK,  8'h0);
        push_exp("ab_hrq",   S_HRQ,   8'h0);
        push_exp("ab_valid", S_VALID, 8'h0);
        push_exp("ab_order", S_ORDER, 8'hE4);
        push_exp("ab_src",   S_SRC,   8'h0);
        step();

        // Reset mid-grant with a rotated order
        DREQ = 4'b0001;
        HLDA = 1'b1;
        step();
        step();
        serviceDone = 1'b1;
        push_exp("rm_order", S_ORDER, 8'h39);
        step();
        serviceDone = 1'b0;
        step();
        step();
        push_exp("rm_dack", S_DACK, 8'h1);
        step();
        RESET = 1'b1;
        push_exp("rm_rst_dack",  S_DACK,  8'h0);
        push_exp("rm_rst_hrq",   S_HRQ,   8'h0);
        push_exp("rm_rst_order", S_ORDER, 8'hE4);
        push_exp("rm_rst_pend",  S_PEND,  8'h0);
        step();
        RESET = 1'b0;

        // Controller disable blocks and cancels requests
        controllerDisable = 1'b1;
        push_exp("dis_idle_hrq", S_HRQ, 8'h0);
        step();
        controllerDisable = 1'b0;
        push_exp("dis_off_hrq", S_HRQ, 8'h1);
        step();
        controllerDisable = 1'b1;
        push_exp("dis_req_hrq",  S_HRQ,  8'h0);
        push_exp("dis_req_dack", S_DACK, 8'h0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
